// File: rtl/cpu_host_loader.sv
// cpu_host_loader
//   Host-side initiator for the CPU external memory ports. Commands arrive on a
//   valid/ready stream and either preload instruction/data memory from the
//   in_* word stream, release the core for a bounded number of cycles, or dump
//   data memory back out on the out_* stream. This block is the only driver of
//   the CPU *_ext* and enable inputs.
//
//   Optional feature macro: CPU_HOST_LOADER_CHECKSUM_EN
//     defined   -> checksum is a running 32-bit sum of every word written or
//                  dumped, cleared on each command accept
//     undefined -> checksum is tied to 0
//
// Ports
//   clk, arst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_op/cmd_addr/cmd_len        0=LOAD_IMEM 1=LOAD_DMEM 2=RUN 3=DUMP_DMEM,
//                                  start byte address, word count or run cycles
//   in_valid/in_ready/in_data      write-data stream for LOAD_*
//   out_valid/out_ready/out_data   dump-data stream for DUMP_DMEM
//   addr_ext/wen_ext/ren_ext/wdata_ext          instruction-memory port
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2  data-memory port
//   rdata_ext_2                    data-memory read data (one cycle after ren)
//   enable                         CPU run enable (only high in RUN)
//   busy, done, checksum           status
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a command, cmd_ready high
// WRITE  | accepting in_* words, one memory write per handshake
// RD_REQ | ren_ext_2 asserted at the current address
// RD_CAP | read data returns, captured into out_data
// RD_OUT | out_valid held until the consumer takes the word
// RUN    | enable high, down-counting the cycle budget

module cpu_host_loader #(
  parameter int LEN_W     = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [31:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [31:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [31:0]      wdata_ext_2,
  input  logic [31:0]      rdata_ext_2,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic [31:0]      checksum
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_RD_REQ = 3'd2,
    S_RD_CAP = 3'd3,
    S_RD_OUT = 3'd4,
    S_RUN    = 3'd5
  } state_t;

  localparam logic [1:0]       OP_LOAD_IMEM = 2'd0;
  localparam logic [1:0]       OP_LOAD_DMEM = 2'd1;
  localparam logic [1:0]       OP_RUN       = 2'd2;
  localparam logic [31:0]      STEP         = 32'(ADDR_STEP);
  localparam logic [LEN_W-1:0] LEN_ONE      = LEN_W'(1);

  state_t           state;
  logic [1:0]       op_q;
  logic [31:0]      cur;
  logic [LEN_W-1:0] remaining;

  logic cmd_fire;
  logic in_fire;
  logic out_fire;
  logic last_word;

  // cmd_ready is gated by reset so the host never sees a ready while held in reset
  assign cmd_ready = (state == S_IDLE) && arst_n;
  assign in_ready  = (state == S_WRITE);
  assign busy      = (state != S_IDLE);
  assign ren_ext   = 1'b0;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_word = (remaining == LEN_ONE);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= S_IDLE;
      op_q        <= OP_LOAD_IMEM;
      cur         <= '0;
      remaining   <= '0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      enable      <= 1'b0;
      done        <= 1'b0;
    end else begin
      // strobes are single-cycle unless re-asserted below
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      ren_ext_2 <= 1'b0;
      done      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            op_q      <= cmd_op;
            cur       <= cmd_addr;
            remaining <= cmd_len;
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              case (cmd_op)
                OP_LOAD_IMEM, OP_LOAD_DMEM: state <= S_WRITE;
                OP_RUN: begin
                  state  <= S_RUN;
                  enable <= 1'b1;
                end
                default: begin
                  // request issued on entry so ren_ext_2 is high during RD_REQ
                  state      <= S_RD_REQ;
                  ren_ext_2  <= 1'b1;
                  addr_ext_2 <= cmd_addr;
                end
              endcase
            end
          end
        end

        S_WRITE: begin
          if (in_fire) begin
            if (op_q == OP_LOAD_IMEM) begin
              wen_ext   <= 1'b1;
              addr_ext  <= cur;
              wdata_ext <= in_data;
            end else begin
              wen_ext_2   <= 1'b1;
              addr_ext_2  <= cur;
              wdata_ext_2 <= in_data;
            end
            cur       <= cur + STEP;
            remaining <= remaining - LEN_ONE;
            if (last_word) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
        end

        S_RD_REQ: state <= S_RD_CAP;

        S_RD_CAP: begin
          out_data  <= rdata_ext_2;
          out_valid <= 1'b1;
          state     <= S_RD_OUT;
        end

        S_RD_OUT: begin
          if (out_fire) begin
            out_valid <= 1'b0;
            cur       <= cur + STEP;
            remaining <= remaining - LEN_ONE;
            if (last_word) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              state      <= S_RD_REQ;
              ren_ext_2  <= 1'b1;
              addr_ext_2 <= cur + STEP;
            end
          end
        end

        S_RUN: begin
          remaining <= remaining - LEN_ONE;
          if (last_word) begin
            enable <= 1'b0;
            state  <= S_IDLE;
            done   <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CPU_HOST_LOADER_CHECKSUM_EN
  // in_fire and out_fire are mutually exclusive (different states)
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      checksum <= '0;
    end else if (cmd_fire) begin
      checksum <= '0;
    end else if (in_fire) begin
      checksum <= checksum + in_data;
    end else if (out_fire) begin
      checksum <= checksum + out_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_cpu_host_loader.sv
`timescale 1ns/1ps
module tb_cpu_host_loader;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             arst_n = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [31:0]      cmd_addr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic [31:0]      addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, checksum;
  logic             wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0]      rdata_ext_2 = '0;
  logic             enable, busy, done;

  always #5 clk = ~clk;

  cpu_host_loader #(.LEN_W(LEN_W), .ADDR_STEP(4)) dut (
    .clk(clk), .arst_n(arst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .enable(enable), .busy(busy), .done(done), .checksum(checksum)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- environment: data memory and port monitors ----------------
  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  typedef struct { logic [31:0] a; logic [31:0] d; } acc_t;

  int          cyc_cnt = 0;
  acc_t        imem_log[$];
  acc_t        dmem_log[$];
  int          imem_cyc[$];
  logic [31:0] ren_log[$];
  logic [31:0] out_log[$];
  int          en_q[$];
  int          done_q[$];
  int          busy_cycles = 0;
  int          ren0_cnt = 0;
  logic [31:0] env_dmem [logic [31:0]];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // read data is only meaningful the cycle after ren_ext_2; junk otherwise
  always @(posedge clk) begin
    if (ren_ext_2)
      rdata_ext_2 <= env_dmem.exists(addr_ext_2) ? env_dmem[addr_ext_2] : mem_default(addr_ext_2);
    else
      rdata_ext_2 <= $urandom;
  end

  always @(negedge clk) begin
    if (wen_ext) begin
      imem_log.push_back('{a: addr_ext, d: wdata_ext});
      imem_cyc.push_back(cyc_cnt);
    end
    if (wen_ext_2) begin
      dmem_log.push_back('{a: addr_ext_2, d: wdata_ext_2});
      env_dmem[addr_ext_2] = wdata_ext_2;
    end
    if (ren_ext_2) ren_log.push_back(addr_ext_2);
    if (out_valid && out_ready) out_log.push_back(out_data);
    if (enable) en_q.push_back(cyc_cnt);
    if (busy) busy_cycles++;
    if (done) done_q.push_back(cyc_cnt);
    if (ren_ext) ren0_cnt++;
  end

  // ---------------- reference model: expected data-memory contents ----------------
  logic [31:0] mdl_dmem [logic [31:0]];

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    return mdl_dmem.exists(a) ? mdl_dmem[a] : mem_default(a);
  endfunction

  logic [31:0] wq[$];
  int          acc_cyc;

  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input int len);
    int t = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = LEN_W'(len);
    while (!cmd_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!cmd_ready) check("cmd_accept_timeout", 32'd0, 32'd1);
    acc_cyc = cyc_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = $urandom; cmd_len = LEN_W'($urandom);
  endtask

  // stress: for DUMP, number of cycles out_ready is held low on the first word;
  //         for RUN, nonzero keeps a junk command valid while busy
  task automatic do_cmd(input logic [1:0] op, input logic [31:0] addr, input int len,
                        input int stall_pct, input int stress,
                        output logic [31:0] first_a, output logic [31:0] last_a);
    int im0 = imem_log.size();
    int dm0 = dmem_log.size();
    int rn0 = ren_log.size();
    int ou0 = out_log.size();
    int en0 = en_q.size();
    int dn0 = done_q.size();
    int bz0 = busy_cycles;
    int r00 = ren0_cnt;
    int idx = 0, cyc = 0, held = 0, ov_first = -1;
    logic [31:0] words[$];
    logic [31:0] sum = '0, first_word = '0, a, e;
    first_a = '0; last_a = '0;
    if (op < 2) for (int i = 0; i < len; i++) words.push_back(wq.size() > 0 ? wq.pop_front() : $urandom);
    issue(op, addr, len);
    while (done_q.size() == dn0 && cyc < 400) begin
      in_valid  = (op < 2 && idx < len && $urandom_range(99) >= stall_pct);
      in_data   = in_valid ? words[idx] : $urandom;
      out_ready = ($urandom_range(99) >= stall_pct);
      cmd_valid = (op == 2 && stress != 0 && busy);
      if (cmd_valid) cmd_len = LEN_W'(3);
      if (op == 3 && out_valid && ov_first < 0) begin ov_first = cyc_cnt; first_word = out_data; end
      if (op == 3 && ov_first >= 0 && held < stress) begin
        out_ready = 1'b0;
        held++;
        check("dump_stall_data", out_data, first_word);
        check("dump_stall_valid", 32'(out_valid), 32'd1);
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0; cmd_valid = 1'b0;
    if (done_q.size() == dn0) check("done_timeout", 32'd0, 32'd1);
    repeat (3) begin @(posedge clk); #1; end

    check("done_count", done_q.size() - dn0, 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
    check("imem_wr_count", imem_log.size() - im0, (op == 0) ? len : 0);
    check("dmem_wr_count", dmem_log.size() - dm0, (op == 1) ? len : 0);
    check("ren_count", ren_log.size() - rn0, (op == 3) ? len : 0);
    check("out_count", out_log.size() - ou0, (op == 3) ? len : 0);
    check("enable_cycles", en_q.size() - en0, (op == 2) ? len : 0);
    check("ren_ext_zero", ren0_cnt - r00, 32'd0);
    if (len == 0 || op == 2) begin
      if (done_q.size() > dn0) check("done_cycle", done_q[dn0], acc_cyc + len + 1);
      check("busy_cycles", busy_cycles - bz0, len);
    end
    if (op == 2 && len > 0 && en_q.size() > en0) check("enable_first", en_q[en0], acc_cyc + 1);

    for (int i = 0; i < len; i++) begin
      a = addr + 32'(4 * i);
      if (op == 0 && imem_log.size() > im0 + i) begin
        check("imem_addr", imem_log[im0 + i].a, a);
        check("imem_data", imem_log[im0 + i].d, words[i]);
      end
      if (op == 1 && dmem_log.size() > dm0 + i) begin
        check("dmem_addr", dmem_log[dm0 + i].a, a);
        check("dmem_data", dmem_log[dm0 + i].d, words[i]);
      end
      if (op == 3) begin
        e = mdl_rd(a);
        sum += e;
        if (ren_log.size() > rn0 + i) check("dump_addr", ren_log[rn0 + i], a);
        if (out_log.size() > ou0 + i) check("dump_data", out_log[ou0 + i], e);
      end
      if (op < 2) sum += words[i];
      if (op == 1) mdl_dmem[a] = words[i];
    end

    if (len > 0 && op == 0 && imem_log.size() >= im0 + len) begin
      first_a = imem_log[im0].a; last_a = imem_log[im0 + len - 1].a;
      if (stall_pct == 0) begin
        check("wr_latency", imem_cyc[im0], acc_cyc + 2);
        check("wr_back_to_back", imem_cyc[im0 + len - 1] - imem_cyc[im0], len - 1);
      end
    end
    if (len > 0 && op == 1 && dmem_log.size() >= dm0 + len) begin
      first_a = dmem_log[dm0].a; last_a = dmem_log[dm0 + len - 1].a;
    end
    if (len > 0 && op == 3) begin
      check("dump_ov_latency", ov_first, acc_cyc + 3);
      if (ren_log.size() >= rn0 + len) begin first_a = ren_log[rn0]; last_a = ren_log[rn0 + len - 1]; end
    end
`ifdef CPU_HOST_LOADER_CHECKSUM_EN
    check("checksum", checksum, sum);
`else
    check("checksum_off", checksum, 32'd0);
`endif
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    int          len;
    int          stall;
    int          stress;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] fa, la;
    int dn0, t;

    vecs[0] = '{2'd1, 32'hFFFF_FFFC, 2, 0, 0, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[1] = '{2'd1, 32'h0000_0010, 4, 0, 0, 32'h0000_0010, 32'h0000_001C};
    vecs[2] = '{2'd3, 32'h0000_0010, 2, 0, 4, 32'h0000_0010, 32'h0000_0014};
    vecs[3] = '{2'd2, 32'h0000_0000, 5, 0, 1, 32'h0, 32'h0};
    vecs[4] = '{2'd0, 32'h0000_0100, 5, 40, 0, 32'h0000_0100, 32'h0000_0110};
    vecs[5] = '{2'd3, 32'hFFFF_FFFC, 3, 30, 0, 32'hFFFF_FFFC, 32'h0000_0004};
    vecs[6] = '{2'd0, 32'h0000_0040, 0, 0, 0, 32'h0, 32'h0};
    vecs[7] = '{2'd1, 32'h0000_0040, 0, 0, 0, 32'h0, 32'h0};
    vecs[8] = '{2'd2, 32'h0000_0040, 0, 0, 0, 32'h0, 32'h0};
    vecs[9] = '{2'd3, 32'h0000_0040, 0, 0, 0, 32'h0, 32'h0};

    // power-on reset
    #1 arst_n = 1'b0;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_wen", {30'd0, wen_ext, wen_ext_2}, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_addr", addr_ext | addr_ext_2 | out_data, 32'd0);
    check("rst_checksum", checksum, 32'd0);
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;
    #1;
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;

    // instruction preload with known words, back to back
    wq = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820};
    do_cmd(2'd0, 32'h0, 3, 0, 0, fa, la);
    check("imem_first", fa, 32'h0);
    check("imem_last", la, 32'h8);

    for (int v = 0; v < 10; v++) begin
      do_cmd(vecs[v].op, vecs[v].addr, vecs[v].len, vecs[v].stall, vecs[v].stress, fa, la);
      if (vecs[v].len > 0 && vecs[v].op != 2) begin
        check($sformatf("vec%0d_first_addr", v), fa, vecs[v].exp_first);
        check($sformatf("vec%0d_last_addr", v), la, vecs[v].exp_last);
      end
    end

    // randomized commands against the model
    for (int r = 0; r < 12; r++) begin
      logic [1:0]  op;
      logic [31:0] addr;
      op   = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : 32'h10 + 32'(4 * $urandom_range(0, 8));
      do_cmd(op, addr, $urandom_range(0, 6), $urandom_range(0, 50), 0, fa, la);
    end

    // reset in the middle of a load: wen must drop immediately, no done
    dn0 = done_q.size();
    issue(2'd0, 32'h200, 4);
    in_valid = 1'b1; in_data = 32'h1111_0000;
    @(posedge clk); #1;
    check("mid_wr_wen", 32'(wen_ext), 32'd1);
    arst_n = 1'b0;
    #1;
    check("abort_wen", 32'(wen_ext), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_enable", 32'(enable), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    #1;
    check("abort_rel_ready", 32'(cmd_ready), 32'd1);
    check("abort_rel_done", 32'(done), 32'd0);

    // reset in the middle of a run: enable must drop immediately
    issue(2'd2, 32'h0, 10);
    t = 0;
    while (!enable && t < 5) begin @(posedge clk); #1; t++; end
    check("mid_run_enable", 32'(enable), 32'd1);
    arst_n = 1'b0;
    #1;
    check("abort_run_enable", 32'(enable), 32'd0);
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_no_done", done_q.size() - dn0, 32'd0);

    // the load after an abort starts cleanly
    do_cmd(2'd0, 32'h300, 2, 0, 0, fa, la);
    check("post_abort_first", fa, 32'h300);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
